// File: rtl/imem_loader_pkg.sv
// Shared loader/IMEM definitions: FSM state encodings, default IMEM geometry.
package imem_loader_pkg;
  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DEPTH  = 256;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5,
    ST_CSUM   = 3'd6
  } ld_state_t;
endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: host byte stream in, IMEM write port and status out.
// master = host/byte source side, slave = loader side.
interface imem_loader_if #(parameter int ADDR_W = imem_loader_pkg::IMEM_ADDR_W);
  logic              start;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  modport master (output start, s_valid, s_data,
                  input  s_ready, im_we, im_addr, im_wdata, cpu_hold, busy, done, err);
  modport slave  (input  start, s_valid, s_data,
                  output s_ready, im_we, im_addr, im_wdata, cpu_hold, busy, done, err);
endinterface

// File: rtl/imem_loader_word_packer.sv
// word_packer: collects 4 stream bytes little-endian into a 32-bit word.
// o_word_valid/o_word are combinational on the 4th byte so the caller can
// register the write in the same edge that accepts the byte.
module word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic        o_word_valid,
  output logic [31:0] o_word
);
  logic [1:0]  r_cnt;
  logic [31:0] r_sr;

  // Newest byte enters at the top, so the first byte ends in [7:0].
  assign o_word       = {i_data, r_sr[31:8]};
  assign o_word_valid = i_en && (r_cnt == 2'd3);

  // Byte counter and shift register; a new load discards any partial word.
  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_cnt <= 2'd0;
      r_sr  <= 32'd0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 2'd1;
      r_sr  <= o_word;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader into instruction memory.
// Holds the CPU in reset until a clean load finishes.
// Optional: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);
  localparam logic [16:0]       LP_DEPTH = 17'(DEPTH);
  localparam logic [ADDR_W:0]   LP_WLAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LP_ALAST = ADDR_W'(DEPTH - 1);

  ld_state_t         r_state;
  logic              r_s_ready, r_im_we, r_cpu_hold, r_done, r_err;
  logic [ADDR_W-1:0] r_im_addr;
  logic [31:0]       r_im_wdata;
  logic [7:0]        r_len_lo;
  logic [15:0]       r_remain;   // words still expected in the stream
  logic [ADDR_W:0]   r_written;  // words actually written this load

  logic        w_accept, w_start, w_pack_en, w_word_valid, w_last;
  logic [31:0] w_word;
  logic [15:0] w_len;

  assign w_accept  = bus.s_valid && r_s_ready;
  assign w_start   = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_pack_en = w_accept && (r_state == ST_DATA || r_state == ST_DRAIN);
  assign w_len     = {bus.s_data, r_len_lo};
  // Last byte of the length+data body: empty program, or final word's 4th byte.
  assign w_last    = (w_accept && r_state == ST_LEN_HI && w_len == 16'd0) ||
                     (w_word_valid && r_remain == 16'd1);

  word_packer u_pack (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_start),
    .i_en         (w_pack_en),
    .i_data       (bus.s_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_xor;
  logic       w_csum_bad;
  assign w_csum_bad = bus.s_data != r_xor;

  // Running XOR over every data byte, drained ones included.
  always_ff @(posedge clk) begin
    if (!rst || w_start) r_xor <= 8'd0;
    else if (w_pack_en)  r_xor <= r_xor ^ bus.s_data;
  end
`endif

  // Loader FSM with registered handshake, write-port and status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_s_ready  <= 1'b0;
      r_im_we    <= 1'b0;
      r_im_addr  <= '0;
      r_im_wdata <= 32'd0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_len_lo   <= 8'd0;
      r_remain   <= 16'd0;
      r_written  <= '0;
    end else begin
      r_im_we <= 1'b0;
      // Address advances after the pulse; it saturates rather than wrapping.
      if (r_im_we && r_im_addr != LP_ALAST) r_im_addr <= r_im_addr + ADDR_W'(1);

      case (r_state)
        ST_LEN_LO: if (w_accept) begin
          r_len_lo <= bus.s_data;
          r_state  <= ST_LEN_HI;
        end
        ST_LEN_HI: if (w_accept) begin
          r_remain <= w_len;
          r_state  <= ST_DATA;
          if ({1'b0, w_len} > LP_DEPTH) r_err <= 1'b1;
        end
        ST_DATA: if (w_word_valid) begin
          r_im_we    <= 1'b1;
          r_im_wdata <= w_word;
          r_remain   <= r_remain - 16'd1;
          r_written  <= r_written + (ADDR_W+1)'(1);
          if (r_written == LP_WLAST) r_state <= ST_DRAIN;
        end
        ST_DRAIN: if (w_word_valid) r_remain <= r_remain - 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM: if (w_accept) begin
          r_state    <= ST_DONE;
          r_s_ready  <= 1'b0;
          r_done     <= 1'b1;
          r_err      <= r_err | w_csum_bad;
          r_cpu_hold <= r_err | w_csum_bad;
        end
`endif
        default: ;
      endcase

      if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_state    <= ST_CSUM;
`else
        r_state    <= ST_DONE;
        r_s_ready  <= 1'b0;
        r_done     <= 1'b1;
        r_cpu_hold <= r_err;
`endif
      end

      if (w_start) begin
        r_state    <= ST_LEN_LO;
        r_s_ready  <= 1'b1;
        r_cpu_hold <= 1'b1;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
        r_im_addr  <= '0;
        r_written  <= '0;
      end
    end
  end

  assign bus.s_ready  = r_s_ready;
  assign bus.im_we    = r_im_we;
  assign bus.im_addr  = r_im_addr;
  assign bus.im_wdata = r_im_wdata;
  assign bus.cpu_hold = r_cpu_hold;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.busy     = !(r_state == ST_IDLE || r_state == ST_DONE);
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: small-depth instance (DEPTH=4, ADDR_W=2) so overflow
// and address saturation are reachable; expected writes/status come from a
// word-list model of the stream format.
module tb_imem_loader;
  localparam int AW = 2;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(AW)) ifc ();
  imem_loader #(.ADDR_W(AW), .DEPTH(DP)) dut (.clk(clk), .rst(rst), .bus(ifc));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int            wc_q[$];
  logic [31:0]   wd[$];

  always @(posedge clk) cyc++;

  // Write-port monitor
  always @(negedge clk)
    if (ifc.im_we === 1'b1) begin
      wa_q.push_back(ifc.im_addr);
      wd_q.push_back(ifc.im_wdata);
      wc_q.push_back(cyc);
    end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_rst_vals();
    chk("rst_s_ready",  64'(ifc.s_ready),  0);
    chk("rst_im_we",    64'(ifc.im_we),    0);
    chk("rst_im_addr",  64'(ifc.im_addr),  0);
    chk("rst_im_wdata", 64'(ifc.im_wdata), 0);
    chk("rst_cpu_hold", 64'(ifc.cpu_hold), 1);
    chk("rst_busy",     64'(ifc.busy),     0);
    chk("rst_done",     64'(ifc.done),     0);
    chk("rst_err",      64'(ifc.err),      0);
  endtask

  task automatic fill_rand(input int n);
    wd.delete();
    for (int i = 0; i < n; i++) wd.push_back($urandom);
  endtask

  // Streams the program in wd. stop_after>0 sends only that many bytes and
  // returns without end-of-load checks.
  task automatic do_load(input bit gaps, input bit mid, input bit corrupt, input int stop_after);
    logic [7:0] bytes[$];
    logic [7:0] x;
    int n, nb, idx, k, nw;
    bit exp_err;
    n = wd.size();
    x = 8'd0;
    bytes.push_back(8'(n));
    bytes.push_back(8'(n >> 8));
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 4; b++) begin
        bytes.push_back(8'(wd[i] >> (8 * b)));
        x ^= 8'(wd[i] >> (8 * b));
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
    bytes.push_back(x ^ {7'd0, corrupt});
`endif
    nb = (stop_after > 0) ? stop_after : bytes.size();
    wa_q.delete(); wd_q.delete(); wc_q.delete();

    @(negedge clk) ifc.start = 1'b1;
    @(negedge clk) ifc.start = 1'b0;
    chk("st_busy",     64'(ifc.busy),     1);
    chk("st_s_ready",  64'(ifc.s_ready),  1);
    chk("st_done",     64'(ifc.done),     0);
    chk("st_err",      64'(ifc.err),      0);
    chk("st_cpu_hold", 64'(ifc.cpu_hold), 1);
    chk("st_im_addr",  64'(ifc.im_addr),  0);

    idx = 0; k = 0;
    while (idx < nb) begin
      @(negedge clk);
      ifc.s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      ifc.s_data  = bytes[idx];
      ifc.start   = mid && (idx == 5);
      if (ifc.s_valid && ifc.s_ready) idx++;
      k++;
      if (k > 3000) begin
        chk("stream_timeout", 64'(idx), 64'(nb));
        break;
      end
    end
    @(negedge clk);
    ifc.s_valid = 1'b0;
    ifc.start   = 1'b0;
    #1;
    if (stop_after > 0) return;

    exp_err = n > DP;
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_err = exp_err || corrupt;
`endif
    nw = (n < DP) ? n : DP;
    chk("end_done",     64'(ifc.done),     1);
    chk("end_err",      64'(ifc.err),      64'(exp_err));
    chk("end_cpu_hold", 64'(ifc.cpu_hold), 64'(exp_err));
    chk("end_busy",     64'(ifc.busy),     0);
    chk("end_s_ready",  64'(ifc.s_ready),  0);
    chk("n_writes",     64'(wa_q.size()),  64'(nw));
    for (int i = 0; i < wa_q.size() && i < nw; i++) begin
      chk("w_addr", 64'(wa_q[i]), 64'(i));
      chk("w_data", 64'(wd_q[i]), 64'(wd[i]));
      if (!gaps && i > 0) chk("w_spacing", 64'(wc_q[i] - wc_q[i-1]), 4);
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (n > 0 && n <= DP && wc_q.size() > 0)
      chk("last_we_with_done", 64'(wc_q[wc_q.size()-1]), 64'(cyc));
`endif
    repeat (3) @(negedge clk);
    chk("done_level", 64'(ifc.done),    1);
    chk("no_late_wr", 64'(wa_q.size()), 64'(nw));
  endtask

  initial begin
    logic [31:0] keep[$];
    ifc.start = 1'b0; ifc.s_valid = 1'b0; ifc.s_data = 8'd0;
    repeat (3) @(negedge clk);
    chk_rst_vals();
    rst = 1'b1;
    @(negedge clk);

    wd = '{32'h00500093, 32'h00A00113};
    do_load(0, 0, 0, 0);
    wd.delete();
    do_load(0, 0, 0, 0);             // N=0
    fill_rand(6);
    do_load(0, 0, 0, 0);             // overflow, drains 8 bytes
    fill_rand(4);
    do_load(0, 0, 0, 0);             // exactly full, address saturates
    fill_rand(3);
    keep = wd;
    do_load(1, 0, 0, 0);             // random gaps
    wd = keep;
    do_load(0, 0, 0, 0);             // same words, gap-free
    fill_rand(3);
    do_load(0, 1, 0, 0);             // start mid-load ignored

    // Reset after 6 data bytes of an N=2 load
    fill_rand(2);
    do_load(0, 0, 0, 8);
    rst = 1'b0;
    @(negedge clk) #1;
    rst = 1'b1;
    chk_rst_vals();
    repeat (4) @(negedge clk);
    chk("rst_n_writes", 64'(wa_q.size()), 1);
    if (wa_q.size() > 0) begin
      chk("rst_w_addr", 64'(wa_q[0]), 0);
      chk("rst_w_data", 64'(wd_q[0]), 64'(wd[0]));
    end
    fill_rand(2);
    do_load(0, 0, 0, 0);             // restart after reset

`ifdef IMEM_LOADER_CHECKSUM_EN
    fill_rand(2);
    do_load(0, 0, 1, 0);             // checksum corrupted by 0x01
    fill_rand(6);
    do_load(1, 0, 0, 0);             // checksum covers drained bytes
`endif

    for (int r = 0; r < 4; r++) begin
      fill_rand($urandom_range(0, 7));
      do_load(1'($urandom_range(0, 1)), 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle RISC-V core: accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instructions and writes them into instruction memory through its write port. It is the writer side of the instruction memory that `fetch` reads, and holds the CPU in reset until a clean load completes. The block sits between the host/bench byte source and the instruction memory write port, beside `fetch`.

## Interface
Parameters:
- `ADDR_W`, 8: instruction memory word-address width.
- `DEPTH`, 256: instruction memory depth in words (≤ 2^ADDR_W).

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-low reset (`rst == 0` resets on the next `clk` edge).
- `start` input 1: one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- `s_valid` input 1: byte available on `s_data`.
- `s_data` input 8: stream byte.
- `s_ready` output 1: loader can accept a byte this cycle.
- `im_we` output 1: instruction memory write enable, one-cycle pulse.
- `im_addr` output ADDR_W: word address for the write.
- `im_wdata` output 32: instruction word for the write.
- `cpu_hold` output 1: holds the CPU (fetch PC) in reset while high.
- `busy` output 1: a load is in progress.
- `done` output 1: load finished; level signal, cleared by the next `start`.
- `err` output 1: length overflow (or checksum mismatch); sticky until the next `start`.

## Operation
- A byte transfers on any edge where `s_valid && s_ready`.
- Stream format: `LEN[7:0]`, `LEN[15:8]` (word count N), then 4N data bytes, least-significant byte first.
- FSM states:
  - IDLE: `s_ready=0`. `start` moves to LEN_LO.
  - LEN_LO: stores the low length byte, moves to LEN_HI.
  - LEN_HI: stores the high length byte. If N==0, go to DONE (or CSUM when configured). Otherwise go to DATA.
  - DATA: a 2-bit byte counter packs bytes into the word register. On the 4th byte: write the word, increment the word address, then decrement the remaining count. When the remaining count reaches 0, go to DONE (or CSUM).
  - DRAIN: entered from DATA when N > DEPTH, after DEPTH words are written. Accepts and discards the remaining (N−DEPTH)×4 bytes, then goes to DONE (or CSUM).
  - DONE: `s_ready=0`, `done=1`. `start` re-enters LEN_LO, clears `done`/`err`, resets the address to 0 and asserts `cpu_hold`.
- Overflow (N > DEPTH): set `err` on the LEN_HI accept. Write only addresses 0..DEPTH−1; the address never wraps.
- `cpu_hold`: 1 from reset and throughout any load. Drops to 0 on entry to DONE only if `err==0`; otherwise it stays at 1.
- `busy` = state not in {IDLE, DONE}.
- `start` while busy: ignored.
- Reset mid-load: all state returns to reset values. A partially assembled word is never written.

## Timing
- Reset values: `s_ready=0`, `im_we=0`, `im_addr=0`, `im_wdata=0`, `cpu_hold=1`, `busy=0`, `done=0`, `err=0`, FSM=IDLE.
- `s_ready` is registered. It is 1 in LEN_LO, LEN_HI, DATA, DRAIN and CSUM, starting the cycle after `start` is sampled.
- `im_we`, `im_addr` and `im_wdata` are registered: valid the cycle after the 4th byte of a word is accepted, for exactly one cycle. `im_addr` increments the following cycle.
- Full throughput: one byte per cycle; back-to-back words produce one `im_we` pulse every 4 cycles.
- `done` rises, and `cpu_hold` falls, the cycle after the last stream byte is accepted. This is the same cycle the last `im_we` pulse is seen.
- Gaps in `s_valid` stall the FSM with no state loss.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - Adds state CSUM after DATA/DRAIN, which accepts one extra byte.
  - That byte must equal the XOR of all 4N data bytes, including drained bytes.
  - A mismatch sets `err`, and `cpu_hold` stays at 1.
- Not defined: no CSUM state and no extra byte; `err` reflects overflow only.

## Structure
- Shared CPU package/header holds the FSM state encodings (IDLE, LEN_LO, LEN_HI, DATA, DRAIN, DONE, CSUM), the default IMEM depth and the address width, so `fetch`'s instruction memory and this loader agree.
- One sub-module, `word_packer`: a 2-bit byte counter plus a 32-bit shift register, emitting `word_valid` on the 4th byte. It is cleared by reset and by `start`.

## Test plan
- Load N=2 with words 0x00500093, 0x00A00113 → `im_we` pulses at addresses 0 and 1 with those data; `done=1`, `cpu_hold=0`, `err=0`.
- N=0 → no `im_we`, `done=1` two accepted bytes after `start`, `cpu_hold=0`.
- `DEPTH=4`, N=6 → writes only addresses 0–3, drains 8 bytes, `err=1`, `cpu_hold=1`, `done=1`.
- Random `s_valid` gaps (≈50% duty) on an N=3 load → identical memory contents and write order as the gap-free load.
- Assert `rst=0` after 6 data bytes of an N=2 load → address 0 written once, no partial write to address 1, outputs at reset values. A restart then loads correctly.
- With `IMEM_LOADER_CHECKSUM_EN`: correct XOR byte → `err=0`; XOR byte corrupted by 0x01 → `err=1`, `cpu_hold=1`.
